irr_priority_resolver: RTL

- Upstream neighbour of the in-service register stage in the 8259-style interrupt controller.
- Synchronises the IR0–IR7 request lines and holds them in the interrupt request register (IRR), with edge or level triggering and masking.
- Resolves fixed or rotating priority against the current ISR contents and drives INT to the CPU.
- Runs the two-pulse INTA acknowledge sequence and produces the number_of_ack, irr_highest_bit, isr_highest_bit and higher_priority signals that the ISR stage consumes.

---
 rtl/irr_priority_resolver_if.sv | 30 +++
 rtl/irr_priority_resolver.sv | 134 +++++++++++++
 2 files changed

// File: rtl/irr_priority_resolver_if.sv
// Request/acknowledge bundle between the CPU-side pins, the ISR stage and the IRR priority resolver.
interface irr_priority_resolver_if;
  logic [7:0] ir;
  logic       INTA;
  logic [7:0] imr;
  logic       ltim;
  logic       auto_rotate;
  logic       rotate_pulse;
  logic [2:0] rotate_level;
  logic [7:0] isr;
  logic       int_out;
  logic [7:0] irr;
  logic [7:0] irr_highest_bit;
  logic [7:0] isr_highest_bit;
  logic       higher_priority;
  logic [1:0] number_of_ack;
  logic       spurious;

  modport master (
    output ir, INTA, imr, ltim, auto_rotate, rotate_pulse, rotate_level, isr,
    input  int_out, irr, irr_highest_bit, isr_highest_bit, higher_priority,
           number_of_ack, spurious
  );

  modport slave (
    input  ir, INTA, imr, ltim, auto_rotate, rotate_pulse, rotate_level, isr,
    output int_out, irr, irr_highest_bit, isr_highest_bit, higher_priority,
           number_of_ack, spurious
  );
endinterface

// File: rtl/irr_priority_resolver.sv
// 8259-style IRR stage: synchronises IR/INTA, holds the IRR, resolves fixed/rotating
// priority against the ISR and sequences the two-pulse INTA acknowledge.
module irr_priority_resolver #(
  parameter int SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  irr_priority_resolver_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} ack_state_t;

  ack_state_t state, state_next;

  logic [SYNC_STAGES-1:0][7:0] ir_sync;
  logic [7:0]                  ir_prev;
  logic [SYNC_STAGES-1:0]      inta_sync;
  logic                        inta_prev;

  logic [7:0] irr, irr_next, frozen, ack_clr;
  logic [7:0] irr_cand, irr_hi, isr_hi, ir_s;
  logic [2:0] lowest_prio;
  logic       int_q, spurious_q, hp, inta_s, inta_fall, inta_rise;

  // Highest priority is lowest+1; scan from lowest upward so the last hit wins.
  function automatic logic [7:0] pick_highest(input logic [7:0] v, input logic [2:0] low);
    logic [7:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = low + 3'(k);
      if (v[idx]) res = 8'b1 << idx;
    end
    return res;
  endfunction

  // 0 = highest priority, 7 = lowest.
  function automatic logic [2:0] rank_of(input logic [7:0] oh, input logic [2:0] low);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i) - low - 3'd1;
    return r;
  endfunction

  function automatic logic [2:0] index_of(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_sync   <= '0;
      ir_prev   <= '0;
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      ir_sync[0]   <= bus.ir;
      inta_sync[0] <= bus.INTA;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ir_sync[i]   <= ir_sync[i-1];
        inta_sync[i] <= inta_sync[i-1];
      end
      ir_prev   <= ir_sync[SYNC_STAGES-1];
      inta_prev <= inta_sync[SYNC_STAGES-1];
    end
  end

  assign ir_s      = ir_sync[SYNC_STAGES-1];
  assign inta_s    = inta_sync[SYNC_STAGES-1];
  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  assign irr_cand = pick_highest(irr & ~bus.imr, lowest_prio);
  assign irr_hi   = (state == IDLE) ? irr_cand : frozen;
  assign isr_hi   = pick_highest(bus.isr, lowest_prio);
  assign hp       = (|irr_hi) &&
                    (~|bus.isr || (rank_of(irr_hi, lowest_prio) < rank_of(isr_hi, lowest_prio)));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ack_clr    = '0;
    unique case (state)
      IDLE: if (inta_fall) begin
        state_next = ACK1;
        ack_clr    = irr_cand;
      end
      ACK1: if (inta_fall) state_next = ACK2;
      ACK2: if (inta_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Ack-clear is applied last so it beats a same-cycle set.
    if (bus.ltim) irr_next = ir_s & ~ack_clr;
    else          irr_next = (irr | (ir_s & ~ir_prev)) & ir_s & ~ack_clr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irr         <= '0;
      frozen      <= '0;
      int_q       <= 1'b0;
      spurious_q  <= 1'b0;
      lowest_prio <= 3'd7;
    end else begin
      irr        <= irr_next;
      spurious_q <= (state == IDLE) && inta_fall && (irr_cand == '0);
      if (state == IDLE && inta_fall) frozen <= irr_cand;
      if (state_next != IDLE) int_q <= 1'b1;
      else if (state != IDLE) int_q <= 1'b0;
      else                    int_q <= hp;
      if (bus.rotate_pulse)
        lowest_prio <= bus.rotate_level;
      else if (state == ACK2 && state_next == IDLE && bus.auto_rotate && |frozen)
        lowest_prio <= index_of(frozen);
    end
  end

  assign bus.int_out         = int_q;
  assign bus.irr             = irr;
  assign bus.irr_highest_bit = irr_hi;
  assign bus.isr_highest_bit = isr_hi;
  assign bus.higher_priority = hp;
  assign bus.number_of_ack   = state;
  assign bus.spurious        = spurious_q;

endmodule
